// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: single-outstanding req/gnt/rvalid instruction bus.
//   master (fetch unit): drives req/addr, samples gnt/rvalid/rdata
//   slave  (memory)    : samples req/addr, drives gnt/rvalid/rdata
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'd0
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'd1
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'd2
`endif

interface if_fetch_unit_if;
    logic                  req;
    logic [`CPU_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [`CPU_WIDTH-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end with a 2-entry instruction FIFO.
//   clk, rst        clock, synchronous active-high reset
//   flow_pc_i       flow-control verdict (WORK / STOP; REFRESH acts as STOP)
//   next_pc_i       redirect target
//   next_pc_four_i  1: sequential advance, 0 with WORK: redirect
//   ibus            instruction bus master (req/addr/gnt/rvalid/rdata)
//   inst_o          FIFO head instruction
//   inst_addr_o     PC of FIFO head
//   inst_valid_o    FIFO non-empty
//   bus_wait_o      FIFO empty
//   fetch_err_o     misaligned redirect seen
// Optional macro FETCH_ALIGN_CHK_EN: flag misaligned redirects and halt fetch
// until the next aligned redirect; otherwise the target is word aligned.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'd1
`endif

module if_fetch_unit #(
    parameter logic [`CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`FLOW_WIDTH-1:0] flow_pc_i,
    input  logic [`CPU_WIDTH-1:0]  next_pc_i,
    input  logic                   next_pc_four_i,
    if_fetch_unit_if.master        ibus,
    output logic [`CPU_WIDTH-1:0]  inst_o,
    output logic [`CPU_WIDTH-1:0]  inst_addr_o,
    output logic                   inst_valid_o,
    output logic                   bus_wait_o,
    output logic                   fetch_err_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
    state_t                r_state, w_state_nxt;
    logic [`CPU_WIDTH-1:0] r_req_pc, w_req_pc_nxt;
    logic [`CPU_WIDTH-1:0] r_fifo_addr [2];
    logic [`CPU_WIDTH-1:0] r_fifo_data [2];
    logic                  r_rd_ptr, r_wr_ptr;
    logic [1:0]            r_count;
    logic                  w_work, w_redirect, w_consume, w_credit, w_req, w_push, w_err;
    logic [`CPU_WIDTH-1:0] w_target;

    assign w_work     = flow_pc_i == `FLOW_WORK;
    assign w_redirect = w_work & ~next_pc_four_i;
    assign w_consume  = w_work & next_pc_four_i & inst_valid_o;
    // At most one response is in flight, so occupancy plus outstanding stays <= 2
    assign w_credit   = ({1'b0, r_count} + {2'b0, r_state != S_REQ}) < 3'd2;

`ifdef FETCH_ALIGN_CHK_EN
    logic r_err;
    assign w_target = next_pc_i;
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_redirect)
            r_err <= |next_pc_i[1:0];
    end
    assign w_err = r_err;
`else
    assign w_target = next_pc_i & ~`CPU_WIDTH'd3;
    assign w_err    = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_req_pc_nxt = w_redirect ? w_target : r_req_pc;
        w_req        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = w_credit & ~w_redirect & ~w_err & ~rst;
                if (w_req & ibus.gnt) begin
                    w_req_pc_nxt = r_req_pc + `CPU_WIDTH'd4;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response coinciding with a redirect is stale and is dropped
                if (ibus.rvalid) begin
                    w_push      = ~w_redirect;
                    w_state_nxt = S_REQ;
                end else if (w_redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (ibus.rvalid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_REQ;
            r_req_pc       <= RESET_PC;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_req_pc <= w_req_pc_nxt;
            if (w_redirect) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                // In S_WAIT without a redirect, req_pc is the granted address + 4
                if (w_push) begin
                    r_fifo_addr[r_wr_ptr] <= r_req_pc - `CPU_WIDTH'd4;
                    r_fifo_data[r_wr_ptr] <= ibus.rdata;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_consume)
                    r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_consume};
            end
        end
    end

    assign ibus.req     = w_req;
    assign ibus.addr    = r_req_pc;
    assign inst_o       = r_fifo_data[r_rd_ptr];
    assign inst_addr_o  = r_fifo_addr[r_rd_ptr];
    assign inst_valid_o = r_count != 2'd0;
    assign bus_wait_o   = r_count == 2'd0;
    assign fetch_err_o  = w_err;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scoreboard bench for if_fetch_unit.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'd0
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'd1
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'd2
`endif

module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  flow = `FLOW_STOP;
    logic [31:0] npc = 32'h0;
    logic        four = 1'b1;
    logic [31:0] inst, inst_addr;
    logic        inst_valid, bus_wait, ferr;
    logic        gnt_on = 1'b1;
    int          lat = 1;
    logic        p_act;
    int          p_cnt;
    logic [31:0] p_addr;
    logic [31:0] q_exp [$];
    logic [31:0] q_gnt [$];
    int          n_chk = 0;
    int          n_fail = 0;

    if_fetch_unit_if ibus ();

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .flow_pc_i      (flow),
        .next_pc_i      (npc),
        .next_pc_four_i (four),
        .ibus           (ibus),
        .inst_o         (inst),
        .inst_addr_o    (inst_addr),
        .inst_valid_o   (inst_valid),
        .bus_wait_o     (bus_wait),
        .fetch_err_o    (ferr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign ibus.gnt = gnt_on;

    // Memory model: response arrives lat cycles after grant, in order, reset with the DUT
    always @(posedge clk) begin
        if (rst) begin
            ibus.rvalid <= 1'b0;
            ibus.rdata  <= 32'h0;
            p_act       <= 1'b0;
            p_cnt       <= 0;
        end else begin
            ibus.rvalid <= 1'b0;
            if (p_act) begin
                if (p_cnt == 1) begin
                    ibus.rvalid <= 1'b1;
                    ibus.rdata  <= mem(p_addr);
                    p_act       <= 1'b0;
                end else begin
                    p_cnt <= p_cnt - 1;
                end
            end
            if (ibus.req && ibus.gnt) begin
                q_gnt.push_back(ibus.addr);
                if (lat == 1) begin
                    ibus.rvalid <= 1'b1;
                    ibus.rdata  <= mem(ibus.addr);
                end else begin
                    p_act  <= 1'b1;
                    p_cnt  <= lat - 1;
                    p_addr <= ibus.addr;
                end
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: at the negedge compare any head being consumed this cycle
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (inst_valid && flow == `FLOW_WORK && four) begin
            e = q_exp.size() ? q_exp.pop_front() : 32'hDEAD_BEEF;
            check("pop_addr", inst_addr, e);
            check("pop_data", inst, mem(e));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(logic [31:0] e);
        logic [31:0] g;
        g = q_gnt.size() ? q_gnt.pop_front() : 32'hDEAD_BEEF;
        check("gnt_addr", g, e);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        flow = `FLOW_STOP;
        four = 1'b1;
        lat  = 1;
        repeat (2) cyc();
        q_exp.delete();
        q_gnt.delete();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) cyc();
        check("rst_req", ibus.req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_wait", bus_wait, 1'b1);
        check("rst_inst", inst, 32'h0);
        check("rst_iaddr", inst_addr, 32'h0);
        check("rst_err", ferr, 1'b0);

        // Sequential fetch, 1-cycle memory, first instruction timing
        rst  = 1'b0;
        flow = `FLOW_WORK;
        for (int i = 0; i < 8; i++) q_exp.push_back(32'(4 * i));
        cyc();
        check("t1_valid_lo", inst_valid, 1'b0);
        cyc();
        check("t1_valid_hi", inst_valid, 1'b1);
        check("t1_wait_lo", bus_wait, 1'b0);
        repeat (14) cyc();
        check("t1_pops", 32'(8 - q_exp.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk_gnt(32'(4 * i));

        // Stall: STOP then REFRESH, two words buffered, then drain
        do_reset();
        repeat (5) cyc();
        flow = `FLOW_REFRESH;
        repeat (5) cyc();
        check("t2_req_lo", ibus.req, 1'b0);
        check("t2_valid", inst_valid, 1'b1);
        check("t2_iaddr", inst_addr, 32'h0);
        check("t2_inst", inst, mem(32'h0));
        chk_gnt(32'h0);
        chk_gnt(32'h4);
        check("t2_gnt_cnt", 32'(q_gnt.size()), 32'd0);
        q_exp.push_back(32'h0);
        q_exp.push_back(32'h4);
        q_exp.push_back(32'h8);
        flow = `FLOW_WORK;
        repeat (5) cyc();
        flow = `FLOW_STOP;
        check("t2_drained", 32'(q_exp.size()), 32'd0);

        // Redirect while waiting on 0x8, response 3 cycles after grant
        do_reset();
        flow = `FLOW_WORK;
        q_exp.push_back(32'h0);
        q_exp.push_back(32'h4);
        q_exp.push_back(32'h100);
        q_exp.push_back(32'h104);
        for (int i = 0; i < 20 && !(ibus.req && ibus.addr == 32'h8); i++) cyc();
        check("t3_reach8", ibus.req && ibus.addr == 32'h8, 1'b1);
        lat = 3;
        cyc();
        lat  = 1;
        four = 1'b0;
        npc  = 32'h100;
        cyc();
        four = 1'b1;
        repeat (2) cyc();
        check("t3_req", ibus.req, 1'b1);
        check("t3_addr", ibus.addr, 32'h100);
        repeat (6) cyc();
        check("t3_drained", 32'(q_exp.size()), 32'd0);
        chk_gnt(32'h0);
        chk_gnt(32'h4);
        chk_gnt(32'h8);
        chk_gnt(32'h100);
        chk_gnt(32'h104);

        // Redirect in the same cycle as the response
        do_reset();
        flow = `FLOW_WORK;
        cyc();
        four = 1'b0;
        npc  = 32'h40;
        cyc();
        check("t4_valid", inst_valid, 1'b0);
        check("t4_wait", bus_wait, 1'b1);
        check("t4_req_sup", ibus.req, 1'b0);
        four = 1'b1;
        #1;
        check("t4_req", ibus.req, 1'b1);
        check("t4_addr", ibus.addr, 32'h40);
        q_exp.push_back(32'h40);
        q_exp.push_back(32'h44);
        repeat (5) cyc();
        check("t4_drained", 32'(q_exp.size()), 32'd0);
        chk_gnt(32'h0);
        chk_gnt(32'h40);

        // Address wrap
        do_reset();
        flow = `FLOW_WORK;
        four = 1'b0;
        npc  = 32'hFFFF_FFFC;
        cyc();
        four = 1'b1;
        q_exp.push_back(32'hFFFF_FFFC);
        q_exp.push_back(32'h0);
        #1;
        check("t5_addr_top", ibus.addr, 32'hFFFF_FFFC);
        repeat (2) cyc();
        check("t5_wrap", ibus.addr, 32'h0);
        repeat (3) cyc();
        check("t5_drained", 32'(q_exp.size()), 32'd0);
        chk_gnt(32'hFFFF_FFFC);
        chk_gnt(32'h0);

        // Misaligned redirect
        do_reset();
        flow = `FLOW_WORK;
        four = 1'b0;
        npc  = 32'h102;
        cyc();
        four = 1'b1;
        #1;
`ifdef FETCH_ALIGN_CHK_EN
        check("t6_err_set", ferr, 1'b1);
        repeat (5) cyc();
        check("t6_no_req", ibus.req, 1'b0);
        check("t6_no_gnt", 32'(q_gnt.size()), 32'd0);
        check("t6_valid", inst_valid, 1'b0);
        four = 1'b0;
        npc  = 32'h200;
        cyc();
        four = 1'b1;
        #1;
        check("t6_err_clr", ferr, 1'b0);
        check("t6_req", ibus.req, 1'b1);
        check("t6_addr", ibus.addr, 32'h200);
        q_exp.push_back(32'h200);
`else
        check("t6_err_tied", ferr, 1'b0);
        check("t6_req", ibus.req, 1'b1);
        check("t6_addr", ibus.addr, 32'h100);
        q_exp.push_back(32'h100);
`endif
        repeat (3) cyc();
        check("t6_drained", 32'(q_exp.size()), 32'd0);

        // Reset while a response is outstanding
        do_reset();
        lat = 5;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        lat = 1;
        #1;
        check("t7_valid", inst_valid, 1'b0);
        check("t7_wait", bus_wait, 1'b1);
        check("t7_req", ibus.req, 1'b1);
        check("t7_addr", ibus.addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
